// File: rtl/vsa_dmem_pkg.sv
// ============================================================================
// Module  : vsa_dmem_pkg
// Desc    : Address map, word type and address decode for the vsa_dmem
//           data memory.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package vsa_dmem_pkg;

  typedef logic [4:0] word_t;

  localparam word_t RAM_LAST    = 5'd27;
  localparam word_t ADDR_IO_IN  = 5'd28;
  localparam word_t ADDR_WRCNT  = 5'd29;
  localparam word_t ADDR_TICK   = 5'd30;
  localparam word_t ADDR_IO_OUT = 5'd31;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_IO_IN  = 3'd1,
    REG_WRCNT  = 3'd2,
    REG_TICK   = 3'd3,
    REG_IO_OUT = 3'd4
  } region_e;

  function automatic region_e decode(input word_t a);
    region_e r;
    r = REG_RAM;
    if (a == ADDR_IO_IN)       r = REG_IO_IN;
    else if (a == ADDR_WRCNT)  r = REG_WRCNT;
    else if (a == ADDR_TICK)   r = REG_TICK;
    else if (a == ADDR_IO_OUT) r = REG_IO_OUT;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vsa_dmem_if.sv
// ============================================================================
// Module  : vsa_dmem_if
// Desc    : Core-side data bus of vsa_dmem (address, store data, strobe,
//           load data).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vsa_dmem_if;
  import vsa_dmem_pkg::*;

  word_t addr;
  word_t wdata;
  logic  wr;
  word_t rdata;

  modport master (output addr, output wdata, output wr, input rdata);
  modport slave  (input addr, input wdata, input wr, output rdata);

endinterface

`default_nettype wire

// File: rtl/vsa_sync2.sv
// ============================================================================
// Module  : vsa_sync2
// Desc    : Two-flop synchroniser with asynchronous active-low reset.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsa_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

`default_nettype wire

// File: rtl/vsa_dmem.sv
// ============================================================================
// Module  : vsa_dmem
// Desc    : 32-word data memory: 28 RAM words plus IO_IN, WRCNT, TICK and
//           IO_OUT registers. Combinational read, write on rising edge.
// Options : VSA_DMEM_WRCNT_EN - build the saturating write counter at 29.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module vsa_dmem
  import vsa_dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  vsa_dmem_if.slave  bus,
  input  word_t      io_in,
  output word_t      io_out
);

  region_e region;
  word_t   ram_q [0:27];
  word_t   tick_q, tick_d;
  word_t   io_out_q, io_out_d;
  word_t   io_sync;
  word_t   wrcnt_rd;
  word_t   rd_mux;

  assign region = decode(bus.addr);

  vsa_sync2 #(.WIDTH(5)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (io_in),
    .q_o     (io_sync)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= 27; i++) ram_q[i] <= '0;
    end else if (bus.wr && region == REG_RAM) begin
      ram_q[bus.addr] <= bus.wdata;
    end
  end

  // A load of TICK takes priority over the free-running increment.
  always_comb begin
    tick_d   = tick_q + 5'd1;
    io_out_d = io_out_q;
    if (bus.wr && region == REG_TICK)   tick_d   = bus.wdata;
    if (bus.wr && region == REG_IO_OUT) io_out_d = bus.wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q   <= '0;
      io_out_q <= '0;
    end else begin
      tick_q   <= tick_d;
      io_out_q <= io_out_d;
    end
  end

`ifdef VSA_DMEM_WRCNT_EN
  word_t wrcnt_q, wrcnt_d;

  // Clear on a write to WRCNT itself beats the increment that write implies.
  always_comb begin
    wrcnt_d = wrcnt_q;
    if (bus.wr) begin
      if (region == REG_WRCNT)     wrcnt_d = '0;
      else if (wrcnt_q != 5'd31)   wrcnt_d = wrcnt_q + 5'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wrcnt_q <= '0;
    else          wrcnt_q <= wrcnt_d;
  end

  assign wrcnt_rd = wrcnt_q;
`else
  assign wrcnt_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (region)
      REG_RAM:    rd_mux = ram_q[bus.addr];
      REG_IO_IN:  rd_mux = io_sync;
      REG_WRCNT:  rd_mux = wrcnt_rd;
      REG_TICK:   rd_mux = tick_q;
      REG_IO_OUT: rd_mux = io_out_q;
      default:    rd_mux = '0;
    endcase
  end

  assign bus.rdata = rd_mux;
  assign io_out    = io_out_q;

endmodule

`default_nettype wire

// File: tb/tb_vsa_dmem.sv
// ============================================================================
// Module  : tb_vsa_dmem
// Desc    : Directed scoreboard bench for vsa_dmem; honours VSA_DMEM_WRCNT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vsa_dmem;
  import vsa_dmem_pkg::*;

`ifdef VSA_DMEM_WRCNT_EN
  localparam bit WRCNT_ON = 1'b1;
`else
  localparam bit WRCNT_ON = 1'b0;
`endif

  typedef struct {
    string name;
    bit    is_io;
    word_t exp;
  } exp_t;

  logic  clock;
  logic  reset_n;
  word_t io_in;
  word_t io_out;

  exp_t  sb_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  vsa_dmem_if bus ();

  vsa_dmem dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
    .io_out  (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      while (sb_q.size() > 0) begin
        exp_t e;
        word_t act;
        e   = sb_q.pop_front();
        act = e.is_io ? io_out : bus.rdata;
        n_vec++;
        if (act !== e.exp) begin
          n_miss++;
          $display("FAIL %s: got %0d, expected %0d at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic drive(input word_t a, input word_t d, input logic w);
    @(posedge clock);
    #1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = w;
  endtask

  task automatic exp_rd(input string n, input word_t v);
    sb_q.push_back('{name: n, is_io: 1'b0, exp: v});
  endtask

  task automatic exp_io(input string n, input word_t v);
    sb_q.push_back('{name: n, is_io: 1'b1, exp: v});
  endtask

  initial begin
    word_t rst_addrs [7];
    rst_addrs = '{5'd0, 5'd5, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
    reset_n   = 1'b0;
    io_in     = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wr    = 1'b0;

    // Reset state across the whole map
    foreach (rst_addrs[i]) begin
      drive(rst_addrs[i], 5'd0, 1'b0);
      exp_rd($sformatf("reset_rd_a%0d", rst_addrs[i]), 5'd0);
    end
    exp_io("reset_io_out", 5'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    // TICK: 1 after first edge, 31 after 31 edges, wraps to 0
    for (int k = 1; k <= 31; k++) begin
      drive(ADDR_TICK, 5'd0, 1'b0);
      if (k == 1)  exp_rd("tick_first", 5'd1);
      if (k == 31) exp_rd("tick_31", 5'd31);
    end
    drive(ADDR_TICK, 5'd0, 1'b0);  exp_rd("tick_wrap", 5'd0);
    drive(ADDR_TICK, 5'd20, 1'b1); exp_rd("tick_pre_load", 5'd1);
    drive(ADDR_TICK, 5'd0, 1'b0);  exp_rd("tick_loaded", 5'd20);
    drive(ADDR_TICK, 5'd0, 1'b0);  exp_rd("tick_after_load", 5'd21);

    // Store / load
    drive(5'd5, 5'd19, 1'b1); exp_rd("st5_pre", 5'd0);
    drive(5'd5, 5'd0, 1'b0);  exp_rd("ld5", 5'd19);
    drive(5'd6, 5'd0, 1'b0);  exp_rd("ld6", 5'd0);

    // Read during write
    drive(5'd7, 5'd3, 1'b1);  exp_rd("rdw_init", 5'd0);
    drive(5'd7, 5'd12, 1'b1); exp_rd("rdw_old", 5'd3);
    drive(5'd7, 5'd0, 1'b0);  exp_rd("rdw_new", 5'd12);

    // IO_IN synchroniser latency
    drive(ADDR_IO_IN, 5'd0, 1'b0); io_in = 5'd9; exp_rd("ioin_0edge", 5'd0);
    drive(ADDR_IO_IN, 5'd0, 1'b0); exp_rd("ioin_1edge", 5'd0);
    drive(ADDR_IO_IN, 5'd0, 1'b0); exp_rd("ioin_2edge", 5'd9);

    // IO_OUT
    drive(ADDR_IO_OUT, 5'd17, 1'b1); exp_rd("ioout_rd_pre", 5'd0); exp_io("ioout_pre", 5'd0);
    drive(ADDR_IO_OUT, 5'd0, 1'b0);  exp_rd("ioout_rd", 5'd17);   exp_io("ioout_set", 5'd17);

    // Writes to IO_IN are ignored
    drive(ADDR_IO_IN, 5'd5, 1'b1); exp_rd("ioin_wr_pre", 5'd9);
    drive(ADDR_IO_IN, 5'd0, 1'b0); exp_rd("ioin_wr_ignored", 5'd9); exp_io("ioout_hold", 5'd17);

    // WRCNT: six writes so far, then saturation and clear
    drive(ADDR_WRCNT, 5'd0, 1'b0); exp_rd("wrcnt_6", WRCNT_ON ? 5'd6 : 5'd0);
    for (int k = 0; k < 40; k++) drive(5'd10, word_t'(k), 1'b1);
    drive(ADDR_WRCNT, 5'd0, 1'b0); exp_rd("wrcnt_sat", WRCNT_ON ? 5'd31 : 5'd0);
    drive(5'd10, 5'd0, 1'b0);      exp_rd("ram10_last", 5'd7);
    drive(ADDR_WRCNT, 5'd0, 1'b1); exp_rd("wrcnt_clr_pre", WRCNT_ON ? 5'd31 : 5'd0);
    drive(ADDR_WRCNT, 5'd0, 1'b0); exp_rd("wrcnt_clr", 5'd0);

    // Reset pulse between edges clears state immediately
    drive(5'd3, 5'd8, 1'b1); exp_rd("st3_pre", 5'd0);
    drive(5'd3, 5'd0, 1'b0); exp_rd("ld3", 5'd8); exp_io("ioout_before_rst", 5'd17);
    drive(5'd3, 5'd0, 1'b0);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    exp_rd("ram3_after_rst", 5'd0);
    exp_io("ioout_after_rst", 5'd0);
    drive(ADDR_TICK, 5'd0, 1'b0); exp_rd("tick_after_rst", 5'd1);

    // Write coinciding with reset is aborted
    drive(5'd12, 5'd21, 1'b1);
    reset_n = 1'b0;
    drive(5'd12, 5'd0, 1'b0); exp_rd("abort_in_rst", 5'd0);
    #2 reset_n = 1'b1;
    drive(5'd12, 5'd0, 1'b0); exp_rd("abort_after_rst", 5'd0);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(posedge clock);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
